// File: rtl/lspc_timer_multi_if.sv
// CPU-side bus for lspc_timer_multi: register write strobes and data,
// per-channel IRQ acknowledge, and the IRQ / live-counter outputs.
//   M68K_DATA  16-bit write data
//   WR_SEL     channel select for writes
//   WR_LOW     write reload bits 15:0
//   WR_HIGH    write reload bits 31:16 (ignored for 16-bit counters)
//   WR_CTRL    write control bits 5:0
//   IRQ_ACK    per-channel pending-flag clear strobes
//   IRQ        per-channel interrupt request (pending & enabled)
//   CNT        live counter values, channel 0 in the LSBs
interface lspc_timer_multi_if #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned WIDTH = 32
);
  logic [15:0]          M68K_DATA;
  logic [1:0]           WR_SEL;
  logic                 WR_LOW;
  logic                 WR_HIGH;
  logic                 WR_CTRL;
  logic [NCH-1:0]       IRQ_ACK;
  logic [NCH-1:0]       IRQ;
  logic [NCH*WIDTH-1:0] CNT;

  modport master (
    output M68K_DATA, WR_SEL, WR_LOW, WR_HIGH, WR_CTRL, IRQ_ACK,
    input  IRQ, CNT
  );

  modport slave (
    input  M68K_DATA, WR_SEL, WR_LOW, WR_HIGH, WR_CTRL, IRQ_ACK,
    output IRQ, CNT
  );
endinterface

// File: rtl/lspc_timer_multi.sv
// Multi-channel LSPC raster/IRQ timer: NCH independent WIDTH-bit down-counters
// ticked by the 6 MHz pixel enable, each with write / frame / auto reload,
// one-shot mode, raster-stop gating and a sticky acknowledged IRQ.
//   CLK           system clock
//   nRESETP       asynchronous active-low reset
//   LSPC_EN_6M_N  count / reload tick strobe
//   LSPC_EN_6M_P  input sampling strobe (FRAME_IN, STOP_REQ)
//   FRAME_IN      vblank level; rising edge is the frame reload event
//   STOP_REQ      decoded raster-stop condition
//   bus           CPU register writes, IRQ acknowledge, IRQ and CNT outputs
module lspc_timer_multi #(
  parameter int unsigned NCH        = 2,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RELOAD_DLY = 2
) (
  input  logic                   CLK,
  input  logic                   nRESETP,
  input  logic                   LSPC_EN_6M_N,
  input  logic                   LSPC_EN_6M_P,
  input  logic                   FRAME_IN,
  input  logic                   STOP_REQ,
  lspc_timer_multi_if.slave      bus
);

  logic [WIDTH-1:0] reload_q [NCH];
  logic [WIDTH-1:0] reload_d [NCH];
  logic [WIDTH-1:0] cnt_q    [NCH];
  logic [WIDTH-1:0] cnt_d    [NCH];
  logic [5:0]       ctrl_q   [NCH];
  logic [5:0]       ctrl_d   [NCH];
  logic [1:0]       dly_q    [NCH];
  logic [1:0]       dly_d    [NCH];
  logic [NCH-1:0]   run_q, run_d;
  logic [NCH-1:0]   pend_q, pend_d;
  logic [NCH-1:0]   irq_q, irq_d;
  logic [NCH-1:0]   wrap_q, wrap_d;
  logic             fs1_q, fs1_d, fs2_q, fs2_d, fs3_q, fs3_d;
  logic             frame_pend_q, frame_pend_d;
  logic             stop_q, stop_d;

  always_comb begin
    logic [31:0] rl_ext;
    logic        hit, arm, wr_fire, fr_fire, gated, expire;

    fs1_d        = fs1_q;
    fs2_d        = fs2_q;
    fs3_d        = fs3_q;
    stop_d       = stop_q;
    frame_pend_d = frame_pend_q;
    rl_ext       = '0;
    hit          = 1'b0;
    arm          = 1'b0;
    wr_fire      = 1'b0;
    fr_fire      = 1'b0;
    gated        = 1'b0;
    expire       = 1'b0;

    // Frame edge pending is consumed by the next count tick; a new edge
    // detected in the same CLK takes precedence over the clear.
    if (LSPC_EN_6M_N) frame_pend_d = 1'b0;
    if (LSPC_EN_6M_P) begin
      fs1_d  = FRAME_IN;
      fs2_d  = fs1_q;
      fs3_d  = fs2_q;
      stop_d = STOP_REQ;
      if (fs2_q && !fs3_q) frame_pend_d = 1'b1;
    end

    for (int unsigned i = 0; i < NCH; i++) begin
      reload_d[i] = reload_q[i];
      cnt_d[i]    = cnt_q[i];
      ctrl_d[i]   = ctrl_q[i];
      dly_d[i]    = dly_q[i];
      run_d[i]    = run_q[i];
      wrap_d[i]   = wrap_q[i];

      hit = (bus.WR_SEL == 2'(i));

      if (hit && bus.WR_CTRL) ctrl_d[i] = bus.M68K_DATA[5:0];

      // Build the reload word at 32 bits and truncate, so the high half
      // simply vanishes for 16-bit counters.
      rl_ext = '0;
      rl_ext[WIDTH-1:0] = reload_q[i];
      if (hit && bus.WR_LOW)  rl_ext[15:0]  = bus.M68K_DATA;
      if (hit && bus.WR_HIGH) rl_ext[31:16] = bus.M68K_DATA;
      reload_d[i] = WIDTH'(rl_ext);

      // Write-reload delay: counts down on each tick, fires on reaching the
      // last stage. A fresh write restarts it, suppressing a coincident fire.
      arm     = hit && bus.WR_LOW && ctrl_q[i][0];
      wr_fire = LSPC_EN_6M_N && (dly_q[i] == 2'd1) && !arm;
      if (LSPC_EN_6M_N && (dly_q[i] != 2'd0)) dly_d[i] = dly_q[i] - 2'd1;
      if (arm) dly_d[i] = 2'(RELOAD_DLY);

      fr_fire = LSPC_EN_6M_N && frame_pend_q && ctrl_q[i][1];
      gated   = LSPC_EN_6M_N && run_q[i] && !(ctrl_q[i][5] && stop_q);
      // wrap_q marks a plain expiry that held CNT at 0; the following tick
      // wraps to all-ones instead of expiring again.
      expire  = gated && (cnt_q[i] == '0) && !wrap_q[i];

      if (wr_fire || fr_fire) begin
        cnt_d[i]  = reload_q[i];
        run_d[i]  = 1'b1;
        wrap_d[i] = 1'b0;
      end else if (expire) begin
        if (ctrl_q[i][2])      cnt_d[i]  = reload_q[i];
        else if (ctrl_q[i][3]) run_d[i]  = 1'b0;
        else                   wrap_d[i] = 1'b1;
      end else if (gated) begin
        cnt_d[i]  = cnt_q[i] - 1'b1;
        wrap_d[i] = 1'b0;
      end

      pend_d[i] = (pend_q[i] && !bus.IRQ_ACK[i]) || expire;
      irq_d[i]  = pend_q[i] && ctrl_q[i][4];
    end
  end

  always_ff @(posedge CLK or negedge nRESETP) begin
    if (!nRESETP) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        reload_q[i] <= '0;
        cnt_q[i]    <= '0;
        ctrl_q[i]   <= '0;
        dly_q[i]    <= '0;
      end
      run_q        <= '0;
      pend_q       <= '0;
      irq_q        <= '0;
      wrap_q       <= '0;
      fs1_q        <= 1'b0;
      fs2_q        <= 1'b0;
      fs3_q        <= 1'b0;
      frame_pend_q <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        reload_q[i] <= reload_d[i];
        cnt_q[i]    <= cnt_d[i];
        ctrl_q[i]   <= ctrl_d[i];
        dly_q[i]    <= dly_d[i];
      end
      run_q        <= run_d;
      pend_q       <= pend_d;
      irq_q        <= irq_d;
      wrap_q       <= wrap_d;
      fs1_q        <= fs1_d;
      fs2_q        <= fs2_d;
      fs3_q        <= fs3_d;
      frame_pend_q <= frame_pend_d;
      stop_q       <= stop_d;
    end
  end

  always_comb begin
    bus.IRQ = irq_q;
    bus.CNT = '0;
    for (int unsigned i = 0; i < NCH; i++) bus.CNT[i*WIDTH +: WIDTH] = cnt_q[i];
  end

endmodule

// File: tb/tb_lspc_timer_multi.sv
module tb_lspc_timer_multi;

  logic CLK = 1'b0;
  logic nRESETP = 1'b0;
  logic en_n = 1'b0;
  logic en_p = 1'b0;
  logic frame_in = 1'b0;
  logic stop_req = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 CLK = ~CLK;

  lspc_timer_multi_if #(.NCH(2), .WIDTH(32)) b32 ();
  lspc_timer_multi_if #(.NCH(2), .WIDTH(16)) b16 ();

  lspc_timer_multi #(.NCH(2), .WIDTH(32), .RELOAD_DLY(2)) dut (
    .CLK(CLK), .nRESETP(nRESETP), .LSPC_EN_6M_N(en_n), .LSPC_EN_6M_P(en_p),
    .FRAME_IN(frame_in), .STOP_REQ(stop_req), .bus(b32.slave)
  );

  lspc_timer_multi #(.NCH(2), .WIDTH(16), .RELOAD_DLY(1)) dut16 (
    .CLK(CLK), .nRESETP(nRESETP), .LSPC_EN_6M_N(en_n), .LSPC_EN_6M_P(en_p),
    .FRAME_IN(frame_in), .STOP_REQ(stop_req), .bus(b16.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // kind: 0 = low, 1 = high, 2 = ctrl; which: 0 = 32-bit dut, 1 = 16-bit dut
  task automatic wr(input int which, input logic [1:0] sel, input int kind, input logic [15:0] data);
    @(negedge CLK);
    if (which == 0) begin
      b32.WR_SEL = sel; b32.M68K_DATA = data;
      b32.WR_LOW = (kind == 0); b32.WR_HIGH = (kind == 1); b32.WR_CTRL = (kind == 2);
    end else begin
      b16.WR_SEL = sel; b16.M68K_DATA = data;
      b16.WR_LOW = (kind == 0); b16.WR_HIGH = (kind == 1); b16.WR_CTRL = (kind == 2);
    end
    @(negedge CLK);
    b32.WR_LOW = 1'b0; b32.WR_HIGH = 1'b0; b32.WR_CTRL = 1'b0;
    b16.WR_LOW = 1'b0; b16.WR_HIGH = 1'b0; b16.WR_CTRL = 1'b0;
  endtask

  // One count tick plus an idle CLK so the registered IRQ has settled.
  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK); en_n = 1'b1;
      @(negedge CLK); en_n = 1'b0;
      @(negedge CLK);
    end
  endtask

  task automatic tick_p();
    @(negedge CLK); en_p = 1'b1;
    @(negedge CLK); en_p = 1'b0;
  endtask

  task automatic ack(input logic [1:0] m);
    @(negedge CLK); b32.IRQ_ACK = m;
    @(negedge CLK); b32.IRQ_ACK = 2'b00;
    @(negedge CLK);
  endtask

  initial begin
    b32.M68K_DATA = '0; b32.WR_SEL = '0; b32.WR_LOW = 1'b0; b32.WR_HIGH = 1'b0;
    b32.WR_CTRL = 1'b0; b32.IRQ_ACK = '0;
    b16.M68K_DATA = '0; b16.WR_SEL = '0; b16.WR_LOW = 1'b0; b16.WR_HIGH = 1'b0;
    b16.WR_CTRL = 1'b0; b16.IRQ_ACK = '0;
    repeat (3) @(negedge CLK);
    check("rst_cnt", b32.CNT, 64'h0);
    check("rst_irq", b32.IRQ, 2'b00);
    nRESETP = 1'b1;

    // Ch0 auto-reload, period 5 ticks
    wr(0, 2'd0, 2, 16'h0015);
    wr(0, 2'd0, 1, 16'h0000);
    wr(0, 2'd0, 0, 16'h0004);
    tick_n(1);
    check("c0_dly1", b32.CNT[31:0], 32'h0);
    tick_n(1);
    check("c0_load", b32.CNT[31:0], 32'h4);
    tick_n(4);
    check("c0_zero", b32.CNT[31:0], 32'h0);
    check("c0_noirq", b32.IRQ[0], 1'b0);
    tick_n(1);
    check("c0_auto", b32.CNT[31:0], 32'h4);
    check("c0_irq1", b32.IRQ[0], 1'b1);
    ack(2'b01);
    check("c0_ack1", b32.IRQ[0], 1'b0);
    tick_n(4);
    check("c0_zero2", b32.CNT[31:0], 32'h0);
    check("c0_noirq2", b32.IRQ[0], 1'b0);
    tick_n(1);                                  // k = 0
    check("c0_auto2", b32.CNT[31:0], 32'h4);
    check("c0_irq2", b32.IRQ[0], 1'b1);
    ack(2'b01);
    check("c0_ack2", b32.IRQ[0], 1'b0);

    // Ch1 one-shot
    wr(0, 2'd1, 2, 16'h0018);
    wr(0, 2'd1, 0, 16'h0002);
    tick_n(1);                                  // k = 1
    check("c1_noarm", b32.CNT[63:32], 32'h0);
    wr(0, 2'd1, 2, 16'h0019);
    wr(0, 2'd1, 0, 16'h0002);
    tick_n(2);                                  // k = 3
    check("c1_load", b32.CNT[63:32], 32'h2);
    tick_n(2);                                  // k = 5
    check("c1_zero", b32.CNT[63:32], 32'h0);
    check("c1_noirq", b32.IRQ[1], 1'b0);
    tick_n(1);                                  // k = 6
    check("c1_irq", b32.IRQ[1], 1'b1);
    ack(2'b10);
    tick_n(100);                                // k = 106
    check("c1_hold", b32.CNT[63:32], 32'h0);
    check("c1_noirq100", b32.IRQ[1], 1'b0);
    check("c0_phase", b32.CNT[31:0], 32'h3);

    // Frame reload on ch0 only
    wr(0, 2'd0, 2, 16'h0016);
    wr(0, 2'd0, 0, 16'h0100);
    frame_in = 1'b1;
    tick_p();
    tick_p();
    tick_n(1);                                  // k = 107
    check("fr_early", b32.CNT[31:0], 32'h2);
    tick_p();
    check("fr_pend", b32.CNT[31:0], 32'h2);
    tick_n(1);
    check("fr_c0", b32.CNT[31:0], 32'h100);
    check("fr_c1", b32.CNT[63:32], 32'h0);
    tick_n(1);
    check("fr_once", b32.CNT[31:0], 32'hFF);
    frame_in = 1'b0;

    // Raster-stop gating: ch0 STOP_EN=1, ch1 STOP_EN=0
    wr(0, 2'd0, 2, 16'h0036);
    wr(0, 2'd1, 2, 16'h0005);
    wr(0, 2'd1, 0, 16'h0050);
    tick_n(2);
    check("st_c0a", b32.CNT[31:0], 32'hFD);
    check("st_c1a", b32.CNT[63:32], 32'h50);
    stop_req = 1'b1;
    tick_n(1);
    check("st_lag", b32.CNT[31:0], 32'hFC);
    tick_p();
    tick_n(10);
    check("st_frz0", b32.CNT[31:0], 32'hFC);
    check("st_run1", b32.CNT[63:32], 32'h45);
    stop_req = 1'b0;
    tick_n(1);
    check("st_tail0", b32.CNT[31:0], 32'hFC);
    check("st_tail1", b32.CNT[63:32], 32'h44);
    tick_p();
    tick_n(1);
    check("st_res0", b32.CNT[31:0], 32'hFB);
    check("st_res1", b32.CNT[63:32], 32'h43);

    // Expiry coinciding with a write reload on ch1
    wr(0, 2'd1, 2, 16'h0011);
    wr(0, 2'd1, 0, 16'h0003);
    tick_n(4);
    check("co_one", b32.CNT[63:32], 32'h1);
    wr(0, 2'd1, 0, 16'h1234);
    tick_n(1);
    check("co_zero", b32.CNT[63:32], 32'h0);
    check("co_noirq", b32.IRQ[1], 1'b0);
    tick_n(1);
    check("co_cnt", b32.CNT[63:32], 32'h1234);
    check("co_irq", b32.IRQ[1], 1'b1);
    tick_n(1);
    check("co_sticky", b32.IRQ[1], 1'b1);

    // ACK in the same CLK as a new expiry on ch0
    wr(0, 2'd0, 2, 16'h0015);
    wr(0, 2'd0, 0, 16'h0002);
    ack(2'b01);
    check("ak_clr", b32.IRQ[0], 1'b0);
    tick_n(4);
    check("ak_zero", b32.CNT[31:0], 32'h0);
    @(negedge CLK); en_n = 1'b1; b32.IRQ_ACK = 2'b01;
    @(negedge CLK); en_n = 1'b0; b32.IRQ_ACK = 2'b00;
    @(negedge CLK);
    check("ak_cnt", b32.CNT[31:0], 32'h2);
    check("ak_irq", b32.IRQ[0], 1'b1);
    @(negedge CLK);
    check("ak_irq2", b32.IRQ[0], 1'b1);

    // Asynchronous reset mid-count
    @(negedge CLK); #2 nRESETP = 1'b0;
    #1;
    check("ar_cnt", b32.CNT, 64'h0);
    check("ar_irq", b32.IRQ, 2'b00);
    repeat (2) @(negedge CLK);
    nRESETP = 1'b1;
    tick_n(3);
    check("ar_stopped", b32.CNT, 64'h0);

    // 16-bit build: high-word write absent, RELOAD_DLY=1, out-of-range select
    wr(1, 2'd0, 1, 16'hFFFF);
    wr(1, 2'd0, 2, 16'h0001);
    wr(1, 2'd0, 0, 16'h0005);
    tick_n(1);
    check("w16_load", b16.CNT, 32'h0000_0005);
    wr(1, 2'd3, 2, 16'h0001);
    wr(1, 2'd3, 0, 16'h0007);
    tick_n(1);
    check("w16_sel", b16.CNT, 32'h0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
